// File: rtl/sfp_link_supervisor.sv
// ---------------------------------------------------------------------------
// sfp_link_supervisor
//
// Brings up and recovers one SFP/Aurora link. Everything runs on init_clk.
// The block drives the Aurora reset pins in order: pma_init goes low first,
// then reset_pb. It then waits a bounded time for channel_up. A timeout
// replays the sequence, up to RETRY_MAX consecutive times, after which the
// block parks in FAIL. Removing the module, losing signal, dropping the link,
// or an explicit relink request all send the sequence back to reset.
//
// Parameters
//   GTH_RESET    : cycles pma_init is held in PMA_RST (>=1)
//   CORE_RESET   : cycles of reset_pb-only hold after pma_init release (>=1)
//   LINK_TIMEOUT : cycles allowed in WAIT_UP for channel_up (>=1)
//   RETRY_MAX    : consecutive timeouts before FAIL (1..255)
//
// Ports
//   init_clk    in  : free-running clock for all logic
//   sys_rst_n   in  : asynchronous active-low reset
//   sfp_mod_abs in  : async, 1 = module absent
//   sfp_los     in  : async, 1 = loss of signal
//   channel_up  in  : async (Aurora user clock domain)
//   relink_req  in  : synchronous one-cycle restart request
//   pma_init    out : Aurora pma_init, active high
//   reset_pb    out : Aurora reset_pb, active high
//   link_ok     out : high only in UP
//   link_fail   out : high only in FAIL
//   retry_cnt   out : timeouts since the last success or clear (saturating)
//   state       out : current state code
// ---------------------------------------------------------------------------
module sfp_link_supervisor #(
   parameter int unsigned GTH_RESET    = 50,
   parameter int unsigned CORE_RESET   = 50,
   parameter int unsigned LINK_TIMEOUT = 1000000,
   parameter int unsigned RETRY_MAX    = 3
) (
   input  logic       init_clk,
   input  logic       sys_rst_n,
   input  logic       sfp_mod_abs,
   input  logic       sfp_los,
   input  logic       channel_up,
   input  logic       relink_req,
   output logic       pma_init,
   output logic       reset_pb,
   output logic       link_ok,
   output logic       link_fail,
   output logic [7:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PMA_RST  = 3'd1,
      S_CORE_RST = 3'd2,
      S_WAIT_UP  = 3'd3,
      S_UP       = 3'd4,
      S_FAIL     = 3'd5
   } state_e;

   localparam logic [31:0] GTH_LAST  = 32'(GTH_RESET - 1);
   localparam logic [31:0] CORE_LAST = 32'(CORE_RESET - 1);
   localparam logic [31:0] TMO_LAST  = 32'(LINK_TIMEOUT - 1);
   localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);

   // -------------------------------------------------------------------------
   // Input synchronizers, bit order {channel_up, los, mod_abs}.
   // The reset value makes the link look absent and down, so nothing starts
   // until the real pin levels have propagated through both flops.
   // -------------------------------------------------------------------------
   localparam logic [2:0] SYNC_RST = 3'b011;

   logic [2:0] sync1_q, sync2_q;
   logic       mod_abs_s, los_s, ch_up_s;

   always_ff @(posedge init_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= SYNC_RST;
         sync2_q <= SYNC_RST;
      end else begin
         sync1_q <= {channel_up, sfp_los, sfp_mod_abs};
         sync2_q <= sync1_q;
      end
   end

   assign mod_abs_s = sync2_q[0];
   assign los_s     = sync2_q[1];
   assign ch_up_s   = sync2_q[2];

   // -------------------------------------------------------------------------
   // State, cycle counter and retry count registers
   // -------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  retry_q, retry_d;
   logic        restart;

   always_ff @(posedge init_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   logic [7:0] retry_inc;
   assign retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      restart = 1'b0;
      if (mod_abs_s || los_s) begin
         state_d = S_IDLE;
         retry_d = '0;
      end else if (relink_req && state_q != S_IDLE) begin
         // A relink from inside PMA_RST keeps the state code but must still
         // restart the timing, so the counter is cleared explicitly.
         state_d = S_PMA_RST;
         retry_d = '0;
         restart = 1'b1;
      end else begin
         case (state_q)
            S_IDLE:     state_d = S_PMA_RST;
            S_PMA_RST:  if (cnt_q == GTH_LAST)  state_d = S_CORE_RST;
            S_CORE_RST: if (cnt_q == CORE_LAST) state_d = S_WAIT_UP;
            S_WAIT_UP: begin
               if (ch_up_s) begin
                  state_d = S_UP;
                  retry_d = '0;
               end else if (cnt_q == TMO_LAST) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == RETRY_LIM) ? S_FAIL : S_PMA_RST;
               end
            end
            S_UP:       if (!ch_up_s) state_d = S_PMA_RST;
            S_FAIL:     state_d = S_FAIL;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   assign cnt_d = (state_d != state_q || restart) ? 32'd0 : cnt_q + 32'd1;

   // -------------------------------------------------------------------------
   // Outputs decoded from the next state and registered, so they change on the
   // same edge as state. Every state that asserts pma_init also asserts
   // reset_pb, so reset_pb can never be released before pma_init.
   // -------------------------------------------------------------------------
   logic pma_d, rpb_d, ok_d, fail_d;
   logic pma_q, rpb_q, ok_q, fail_q;

   always_comb begin
      pma_d  = 1'b0;
      rpb_d  = 1'b0;
      ok_d   = 1'b0;
      fail_d = 1'b0;
      case (state_d)
         S_IDLE, S_PMA_RST, S_FAIL: begin
            pma_d = 1'b1;
            rpb_d = 1'b1;
         end
         S_CORE_RST: rpb_d = 1'b1;
         default: ;
      endcase
      ok_d   = (state_d == S_UP);
      fail_d = (state_d == S_FAIL);
   end

   always_ff @(posedge init_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pma_q  <= 1'b1;
         rpb_q  <= 1'b1;
         ok_q   <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         pma_q  <= pma_d;
         rpb_q  <= rpb_d;
         ok_q   <= ok_d;
         fail_q <= fail_d;
      end
   end

   assign pma_init  = pma_q;
   assign reset_pb  = rpb_q;
   assign link_ok   = ok_q;
   assign link_fail = fail_q;
   assign retry_cnt = retry_q;
   assign state     = state_q;

endmodule

// File: doc/sfp_link_supervisor.md
# sfp_link_supervisor

Supervises bring-up and recovery of one SFP/Aurora link in the `init_clk` domain. Sequences `pma_init` and `reset_pb` in the required order, then waits for `channel_up` with a timeout and a bounded retry count. Drops back to reset on module removal, loss of signal, link loss or an explicit relink request. Sits between board-level SFP status pins, the Aurora core's reset inputs, and the system status/CSR logic.

## Interface
- `GTH_RESET`, 50: `pma_init` assertion length in PMA_RST, cycles, ≥1.
- `CORE_RESET`, 50: extra `reset_pb`-only hold after `pma_init` release, cycles, ≥1.
- `LINK_TIMEOUT`, 1000000: cycles allowed in WAIT_UP for `channel_up`, ≥1.
- `RETRY_MAX`, 3: consecutive timeouts before FAIL, 1..255.

Ports:
- `init_clk` in 1: free-running clock; all logic.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `sfp_mod_abs` in 1: asynchronous; 1 = module absent.
- `sfp_los` in 1: asynchronous; 1 = loss of signal.
- `channel_up` in 1: from the Aurora user clock domain; asynchronous here.
- `relink_req` in 1: synchronous single-cycle request to restart the sequence.
- `pma_init` out 1: to the Aurora core, active high.
- `reset_pb` out 1: to the Aurora core, active high.
- `link_ok` out 1: 1 only in UP.
- `link_fail` out 1: 1 only in FAIL.
- `retry_cnt` out 8: timeouts since the last success or clear.
- `state` out 3: current state encoding.

## Operation
- **Synchronizers**
  - `sfp_mod_abs`, `sfp_los` and `channel_up` each pass through a 2-flop synchronizer.
  - Reset values: mod_abs_s = 1, los_s = 1, ch_up_s = 0.
- **State encodings:** IDLE = 0, PMA_RST = 1, CORE_RST = 2, WAIT_UP = 3, UP = 4, FAIL = 5. Codes 6 and 7 recover to IDLE.
- **One 32-bit cycle counter:** cleared on every state change; otherwise increments.
- **Priority of global events in any state:**
  1. mod_abs_s | los_s → IDLE, `retry_cnt` = 0.
  2. Else `relink_req` in any state other than IDLE → PMA_RST, `retry_cnt` = 0.
  3. Else the per-state rules below apply.
- **IDLE:** when mod_abs_s = 0 and los_s = 0 → PMA_RST.
- **PMA_RST:** when cnt = GTH_RESET-1 → CORE_RST.
- **CORE_RST:** when cnt = CORE_RESET-1 → WAIT_UP.
- **WAIT_UP:**
  - ch_up_s = 1 → UP, `retry_cnt` = 0. This takes priority over a timeout in the same cycle.
  - Else, when cnt = LINK_TIMEOUT-1: `retry_cnt` + 1; if the new value = RETRY_MAX → FAIL, else → PMA_RST.
- **UP:** ch_up_s = 0 → PMA_RST; `retry_cnt` unchanged.
- **FAIL:** holds until a global event occurs.
- **Outputs, all registered from next-state** (change on the same edge as `state`):
  - `pma_init` = 1 in IDLE, PMA_RST and FAIL.
  - `reset_pb` = 1 in IDLE, PMA_RST, CORE_RST and FAIL.
  - `link_ok` = (UP); `link_fail` = (FAIL).
- **Invariant:** `pma_init` = 1 implies `reset_pb` = 1. `reset_pb` is always released after `pma_init`, never before.
- `retry_cnt` saturates at 255.

## Timing
- **Reset values:** `state` = IDLE, `pma_init` = 1, `reset_pb` = 1, `link_ok` = 0, `link_fail` = 0, `retry_cnt` = 0, counter = 0.
- Reset is applied asynchronously, mid-operation included; outputs take reset values immediately.
- **Async input latency:** a change stable before edge N reaches the FSM through the synchronizer at edge N+1. `state` and outputs update at edge N+2.
- **`relink_req` latency:** sampled at edge N; `state`/outputs update at edge N.
- **Segment lengths, exact:** `pma_init` high for GTH_RESET cycles in PMA_RST. `reset_pb` high for GTH_RESET+CORE_RESET cycles from PMA_RST entry.
- **Timeout:** WAIT_UP lasts exactly LINK_TIMEOUT cycles absent `channel_up`.
- **Simultaneous events:** a global event in the same cycle as a counter terminal value follows the global event. `relink_req` in IDLE is ignored.

## Test plan
Parameters for all scenarios: GTH_RESET = 4, CORE_RESET = 3, LINK_TIMEOUT = 10, RETRY_MAX = 2.
- **Bring-up:** release `sys_rst_n` with `sfp_mod_abs` = 0, `sfp_los` = 0; raise `channel_up` 5 cycles into WAIT_UP → `pma_init` high 4 cycles and `reset_pb` high 7 cycles after PMA_RST entry; `link_ok` rises 2 edges after `channel_up`; `state` = 4; `retry_cnt` = 0.
- **Retry exhaustion:** `channel_up` held 0 → two WAIT_UP windows of 10 cycles each, the first followed by a PMA_RST replay; then `state` = 5, `link_fail` = 1, `retry_cnt` = 2, `pma_init` = `reset_pb` = 1.
- **Relink from FAIL:** pulse `relink_req` → next edge `state` = 1, `link_fail` = 0, `retry_cnt` = 0; full 4/3 sequence replays.
- **Link drop in UP:** drop `channel_up` → 2 edges later `state` = 1, `link_ok` = 0, `pma_init` = 1.
- **Module removal:** raise `sfp_mod_abs` during CORE_RST → 2 edges later `state` = 0, `pma_init` = 1; lower it → sequence restarts from PMA_RST.
- **Async reset:** assert `sys_rst_n` low mid-WAIT_UP, off-edge → outputs at reset values before the next `init_clk` edge.
